// File: rtl/mc_cpu_pkg.sv
// Shared types and encodings for the multi-cycle 16-bit processor controller.
package mc_cpu_pkg;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC_R,
        EXEC_I,
        WB_ALU,
        ADDR,
        MEM_RD,
        WB_MEM,
        MEM_WR,
        BRANCH,
        JUMP,
        HALT
    } state_e;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_ADDI = 4'h4,
        OP_LD   = 4'h5,
        OP_ST   = 4'h6,
        OP_BEQ  = 4'h7,
        OP_JMP  = 4'h8,
        OP_HALT = 4'hE
    } opcode_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;

    typedef enum logic [2:0] {
        CLS_ALU_R,
        CLS_ALU_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_HALT
    } instr_class_e;

    localparam logic PC_SRC_INC  = 1'b0;
    localparam logic PC_SRC_LOAD = 1'b1;
    localparam logic ADDR_PC     = 1'b0;
    localparam logic ADDR_ALU    = 1'b1;
    localparam logic WB_ALU_SEL  = 1'b0;
    localparam logic WB_MEM_SEL  = 1'b1;

endpackage

// File: rtl/mc_instr_decoder.sv
// Combinational opcode decoder: opcode -> instruction class plus illegal flag.
module mc_instr_decoder
    import mc_cpu_pkg::*;
#(
    parameter int OPCODE_LEN = 4
) (
    input  logic [OPCODE_LEN-1:0] opcode,
    output instr_class_e          instr_class,
    output logic                  illegal
);

    // Undefined opcodes fall into the HALT class so the FSM parks safely.
    always_comb begin
        instr_class = CLS_HALT;
        illegal     = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR: instr_class = CLS_ALU_R;
            OP_ADDI:                       instr_class = CLS_ALU_I;
            OP_LD:                         instr_class = CLS_LOAD;
            OP_ST:                         instr_class = CLS_STORE;
            OP_BEQ:                        instr_class = CLS_BRANCH;
            OP_JMP:                        instr_class = CLS_JUMP;
            OP_HALT:                       instr_class = CLS_HALT;
            default: begin
                instr_class = CLS_HALT;
                illegal     = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle FSM controller: sequences PC, IR, memory, ALU and register file,
// and keeps a sticky illegal-opcode flag and a retired-instruction counter.
module mc_control_unit
    import mc_cpu_pkg::*;
#(
    parameter int DATA_LEN   = 16,
    parameter int OPCODE_LEN = 4,
    parameter int CNT_LEN    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [DATA_LEN-1:0] instr,
    input  logic                alu_zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                mem_addr_sel,
    output logic                ir_wr_en,
    output logic                pc_wr_en,
    output logic                pc_src,
    output logic [1:0]          alu_op,
    output logic                alu_src_b,
    output logic                rf_wr_en,
    output logic                rf_wr_sel,
    output logic                halted,
    output logic                illegal,
    output logic [CNT_LEN-1:0]  retired
);

    state_e                state_q;
    state_e                state_d;
    instr_class_e          instr_class;
    logic                  dec_illegal;
    logic [OPCODE_LEN-1:0] opcode;
    logic                  illegal_q;
    logic [CNT_LEN-1:0]    retire_q;
    logic                  retire_ev;
    logic                  instr_unused;

    assign opcode       = instr[DATA_LEN-1 -: OPCODE_LEN];
    assign instr_unused = ^instr[DATA_LEN-OPCODE_LEN-1:0];

    mc_instr_decoder #(
        .OPCODE_LEN (OPCODE_LEN)
    ) u_decoder (
        .opcode      (opcode),
        .instr_class (instr_class),
        .illegal     (dec_illegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (start) state_d = FETCH;
            FETCH:  if (mem_ready) state_d = DECODE;
            DECODE: begin
                case (instr_class)
                    CLS_ALU_R:  state_d = EXEC_R;
                    CLS_ALU_I:  state_d = EXEC_I;
                    CLS_LOAD,
                    CLS_STORE:  state_d = ADDR;
                    CLS_BRANCH: state_d = BRANCH;
                    CLS_JUMP:   state_d = JUMP;
                    default:    state_d = HALT;
                endcase
            end
            EXEC_R, EXEC_I: state_d = WB_ALU;
            WB_ALU:         state_d = FETCH;
            ADDR:           state_d = (instr_class == CLS_STORE) ? MEM_WR : MEM_RD;
            MEM_RD:         if (mem_ready) state_d = WB_MEM;
            WB_MEM:         state_d = FETCH;
            MEM_WR:         if (mem_ready) state_d = FETCH;
            BRANCH, JUMP:   state_d = FETCH;
            HALT:           state_d = HALT;
            default:        state_d = IDLE;
        endcase
    end

    // ALU controls stay on the effective-address setup through both memory
    // states because the memory address is taken straight from the ALU result.
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = ADDR_PC;
        ir_wr_en     = 1'b0;
        pc_wr_en     = 1'b0;
        pc_src       = PC_SRC_INC;
        alu_op       = ALU_ADD;
        alu_src_b    = 1'b0;
        rf_wr_en     = 1'b0;
        rf_wr_sel    = WB_ALU_SEL;
        halted       = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req      = 1'b1;
                mem_addr_sel = ADDR_PC;
                if (mem_ready) begin
                    ir_wr_en = 1'b1;
                    pc_wr_en = 1'b1;
                    pc_src   = PC_SRC_INC;
                end
            end
            EXEC_R: begin
                alu_op    = opcode[1:0];
                alu_src_b = 1'b0;
            end
            EXEC_I, ADDR: begin
                alu_op    = ALU_ADD;
                alu_src_b = 1'b1;
            end
            WB_ALU: begin
                rf_wr_en  = 1'b1;
                rf_wr_sel = WB_ALU_SEL;
                if (instr_class == CLS_ALU_I) begin
                    alu_op    = ALU_ADD;
                    alu_src_b = 1'b1;
                end else begin
                    alu_op    = opcode[1:0];
                    alu_src_b = 1'b0;
                end
            end
            MEM_RD: begin
                mem_req      = 1'b1;
                mem_addr_sel = ADDR_ALU;
                alu_op       = ALU_ADD;
                alu_src_b    = 1'b1;
            end
            WB_MEM: begin
                rf_wr_en  = 1'b1;
                rf_wr_sel = WB_MEM_SEL;
            end
            MEM_WR: begin
                mem_req      = 1'b1;
                mem_we       = 1'b1;
                mem_addr_sel = ADDR_ALU;
                alu_op       = ALU_ADD;
                alu_src_b    = 1'b1;
            end
            BRANCH: begin
                alu_op    = ALU_SUB;
                alu_src_b = 1'b0;
                if (alu_zero) begin
                    pc_wr_en = 1'b1;
                    pc_src   = PC_SRC_LOAD;
                end
            end
            JUMP: begin
                pc_wr_en = 1'b1;
                pc_src   = PC_SRC_LOAD;
            end
            HALT:    halted = 1'b1;
            default: ;
        endcase
    end

    // An instruction retires on the edge that leaves its final state.
    assign retire_ev = (state_q == WB_ALU) || (state_q == WB_MEM) ||
                       (state_q == BRANCH) || (state_q == JUMP)   ||
                       ((state_q == MEM_WR) && mem_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            if (retire_ev) begin
                retire_q <= retire_q + 1'b1;
            end
            if ((state_q == DECODE) && dec_illegal) begin
                illegal_q <= 1'b1;
            end
        end
    end

    assign retired = retire_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed self-checking bench for mc_control_unit; the counter is built narrow
// so the wrap-around can be reached with a short run of jumps.
module tb_mc_control_unit;

    localparam int TB_CNT_LEN = 8;

    // ctl = {mem_req, mem_we, mem_addr_sel, ir_wr_en, pc_wr_en, pc_src,
    //        alu_op[1:0], alu_src_b, rf_wr_en, rf_wr_sel, halted, illegal}
    localparam logic [12:0] C_IDLE       = 13'b0_0_0_0_0_0_00_0_0_0_0_0;
    localparam logic [12:0] C_FETCH_WAIT = 13'b1_0_0_0_0_0_00_0_0_0_0_0;
    localparam logic [12:0] C_FETCH_ACC  = 13'b1_0_0_1_1_0_00_0_0_0_0_0;
    localparam logic [12:0] C_ADDR       = 13'b0_0_0_0_0_0_00_1_0_0_0_0;
    localparam logic [12:0] C_MEM_RD     = 13'b1_0_1_0_0_0_00_1_0_0_0_0;
    localparam logic [12:0] C_WB_MEM     = 13'b0_0_0_0_0_0_00_0_1_1_0_0;
    localparam logic [12:0] C_MEM_WR     = 13'b1_1_1_0_0_0_00_1_0_0_0_0;
    localparam logic [12:0] C_BR_TAKEN   = 13'b0_0_0_0_1_1_01_0_0_0_0_0;
    localparam logic [12:0] C_BR_NOT     = 13'b0_0_0_0_0_0_01_0_0_0_0_0;
    localparam logic [12:0] C_JUMP       = 13'b0_0_0_0_1_1_00_0_0_0_0_0;
    localparam logic [12:0] C_HALT       = 13'b0_0_0_0_0_0_00_0_0_0_1_0;
    localparam logic [12:0] C_HALT_ILL   = 13'b0_0_0_0_0_0_00_0_0_0_1_1;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic [15:0] instr;
    logic alu_zero;
    logic mem_ready;
    logic mem_req, mem_we, mem_addr_sel, ir_wr_en, pc_wr_en, pc_src;
    logic [1:0] alu_op;
    logic alu_src_b, rf_wr_en, rf_wr_sel, halted, illegal;
    logic [TB_CNT_LEN-1:0] retired;
    logic [12:0] ctl;

    logic [TB_CNT_LEN-1:0] exp_ret;
    int checks = 0;
    int failures = 0;

    assign ctl = {mem_req, mem_we, mem_addr_sel, ir_wr_en, pc_wr_en, pc_src,
                  alu_op, alu_src_b, rf_wr_en, rf_wr_sel, halted, illegal};

    always #5 clk = ~clk;

    mc_control_unit #(
        .DATA_LEN   (16),
        .OPCODE_LEN (4),
        .CNT_LEN    (TB_CNT_LEN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .instr        (instr),
        .alu_zero     (alu_zero),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_wr_en     (ir_wr_en),
        .pc_wr_en     (pc_wr_en),
        .pc_src       (pc_src),
        .alu_op       (alu_op),
        .alu_src_b    (alu_src_b),
        .rf_wr_en     (rf_wr_en),
        .rf_wr_sel    (rf_wr_sel),
        .halted       (halted),
        .illegal      (illegal),
        .retired      (retired)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        start     = 1'b0;
        instr     = 16'h0000;
        alu_zero  = 1'b0;
        mem_ready = 1'b0;
        exp_ret   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic launch();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_fetch(input logic [15:0] ir, input int waits, input string tag);
        for (int i = 0; i < waits; i++) begin
            mem_ready = 1'b0;
            #1;
            checks++;
            if (ctl !== C_FETCH_WAIT) begin
                failures++;
                $display("[TB] FAIL %s_fetch_wait ctl=%b exp=%b", tag, ctl, C_FETCH_WAIT);
            end
            step();
        end
        mem_ready = 1'b1;
        instr     = ir;
        #1;
        checks++;
        if (ctl !== C_FETCH_ACC) begin
            failures++;
            $display("[TB] FAIL %s_fetch_acc ctl=%b exp=%b", tag, ctl, C_FETCH_ACC);
        end
        step();
        mem_ready = 1'b0;
        #1;
        checks++;
        if (ctl !== C_IDLE) begin
            failures++;
            $display("[TB] FAIL %s_decode ctl=%b exp=%b", tag, ctl, C_IDLE);
        end
        step();
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++;
        if (ctl !== C_IDLE || retired !== '0) begin
            failures++;
            $display("[TB] FAIL reset ctl=%b ret=%0d exp ctl=%b ret=0", ctl, retired, C_IDLE);
        end
        step();
        mem_ready = 1'b1;
        #1;
        checks++;
        if (ctl !== C_IDLE) begin
            failures++;
            $display("[TB] FAIL idle_hold ctl=%b exp=%b", ctl, C_IDLE);
        end
        step();
        mem_ready = 1'b0;
    endtask

    task automatic test_add();
        apply_reset();
        launch();
        do_fetch(16'h0123, 0, "add");
        #1;
        checks++;
        if (ctl !== 13'b0_0_0_0_0_0_00_0_0_0_0_0) begin
            failures++;
            $display("[TB] FAIL add_exec ctl=%b exp=%b", ctl, 13'b0);
        end
        step();
        #1;
        checks++;
        if (ctl !== 13'b0_0_0_0_0_0_00_0_1_0_0_0 || retired !== 0) begin
            failures++;
            $display("[TB] FAIL add_wb ctl=%b ret=%0d", ctl, retired);
        end
        step();
        exp_ret++;
        #1;
        checks++;
        if (ctl !== C_FETCH_WAIT || retired !== exp_ret) begin
            failures++;
            $display("[TB] FAIL add_retire ctl=%b ret=%0d exp ret=%0d", ctl, retired, exp_ret);
        end
    endtask

    task automatic test_alu_ops();
        logic [15:0] irs [4];
        logic [1:0]  exp_op;
        logic        exp_b;
        irs = '{16'h1123, 16'h2123, 16'h3123, 16'h4105};
        for (int k = 0; k < 4; k++) begin
            exp_op = (k < 3) ? 2'(k + 1) : 2'b00;
            exp_b  = (k == 3);
            do_fetch(irs[k], 0, "alu");
            #1;
            checks++;
            if (ctl !== {6'b000000, exp_op, exp_b, 4'b0000}) begin
                failures++;
                $display("[TB] FAIL alu_exec ir=%h ctl=%b exp=%b", irs[k], ctl, {6'b0, exp_op, exp_b, 4'b0});
            end
            step();
            #1;
            checks++;
            if (ctl !== {6'b000000, exp_op, exp_b, 1'b1, 3'b000}) begin
                failures++;
                $display("[TB] FAIL alu_wb ir=%h ctl=%b exp=%b", irs[k], ctl, {6'b0, exp_op, exp_b, 4'b1000});
            end
            step();
            exp_ret++;
        end
        checks++;
        if (retired !== exp_ret) begin
            failures++;
            $display("[TB] FAIL alu_retired got=%0d exp=%0d", retired, exp_ret);
        end
    endtask

    task automatic test_store();
        do_fetch(16'h6104, 0, "st");
        #1;
        checks++;
        if (ctl !== C_ADDR) begin
            failures++;
            $display("[TB] FAIL st_addr ctl=%b exp=%b", ctl, C_ADDR);
        end
        step();
        mem_ready = 1'b1;
        #1;
        checks++;
        if (ctl !== C_MEM_WR) begin
            failures++;
            $display("[TB] FAIL st_memwr ctl=%b exp=%b", ctl, C_MEM_WR);
        end
        step();
        mem_ready = 1'b0;
        exp_ret++;
        #1;
        checks++;
        if (ctl !== C_FETCH_WAIT || retired !== exp_ret) begin
            failures++;
            $display("[TB] FAIL st_done ctl=%b ret=%0d exp ret=%0d", ctl, retired, exp_ret);
        end
    endtask

    task automatic test_branch();
        for (int t = 0; t < 2; t++) begin
            do_fetch(16'h7012, 0, "beq");
            alu_zero = (t == 0);
            #1;
            checks++;
            if (ctl !== ((t == 0) ? C_BR_TAKEN : C_BR_NOT)) begin
                failures++;
                $display("[TB] FAIL beq_%0s ctl=%b exp=%b", (t == 0) ? "taken" : "not", ctl,
                         (t == 0) ? C_BR_TAKEN : C_BR_NOT);
            end
            step();
            alu_zero = 1'b0;
            exp_ret++;
            #1;
            checks++;
            if (ctl !== C_FETCH_WAIT || retired !== exp_ret) begin
                failures++;
                $display("[TB] FAIL beq_done ctl=%b ret=%0d exp ret=%0d", ctl, retired, exp_ret);
            end
        end
    endtask

    task automatic test_jump();
        do_fetch(16'h8000, 0, "jmp");
        #1;
        checks++;
        if (ctl !== C_JUMP) begin
            failures++;
            $display("[TB] FAIL jmp ctl=%b exp=%b", ctl, C_JUMP);
        end
        step();
        exp_ret++;
        #1;
        checks++;
        if (retired !== exp_ret) begin
            failures++;
            $display("[TB] FAIL jmp_retired got=%0d exp=%0d", retired, exp_ret);
        end
    endtask

    task automatic test_reset_mem_wr();
        do_fetch(16'h6104, 0, "rstwr");
        step();
        #1;
        checks++;
        if (ctl !== C_MEM_WR) begin
            failures++;
            $display("[TB] FAIL rstwr_memwr ctl=%b exp=%b", ctl, C_MEM_WR);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ctl !== C_IDLE || retired !== '0) begin
            failures++;
            $display("[TB] FAIL rstwr_async ctl=%b ret=%0d exp ctl=%b ret=0", ctl, retired, C_IDLE);
        end
        exp_ret = '0;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        mem_ready = 1'b1;
        step();
        #1;
        checks++;
        if (ctl !== C_IDLE || retired !== '0) begin
            failures++;
            $display("[TB] FAIL rstwr_idle ctl=%b ret=%0d exp ctl=%b ret=0", ctl, retired, C_IDLE);
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_load();
        apply_reset();
        launch();
        do_fetch(16'h5104, 3, "ld");
        #1;
        checks++;
        if (ctl !== C_ADDR) begin
            failures++;
            $display("[TB] FAIL ld_addr ctl=%b exp=%b", ctl, C_ADDR);
        end
        step();
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            #1;
            checks++;
            if (ctl !== C_MEM_RD) begin
                failures++;
                $display("[TB] FAIL ld_memrd cyc=%0d ctl=%b exp=%b", i, ctl, C_MEM_RD);
            end
            step();
        end
        mem_ready = 1'b0;
        #1;
        checks++;
        if (ctl !== C_WB_MEM) begin
            failures++;
            $display("[TB] FAIL ld_wbmem ctl=%b exp=%b", ctl, C_WB_MEM);
        end
        step();
        exp_ret++;
        #1;
        checks++;
        if (ctl !== C_FETCH_WAIT || retired !== exp_ret) begin
            failures++;
            $display("[TB] FAIL ld_done ctl=%b ret=%0d exp ret=%0d", ctl, retired, exp_ret);
        end
    endtask

    task automatic test_halt();
        apply_reset();
        launch();
        do_fetch(16'hE000, 0, "halt");
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            #1;
            checks++;
            if (ctl !== C_HALT || retired !== '0) begin
                failures++;
                $display("[TB] FAIL halt cyc=%0d ctl=%b ret=%0d exp=%b", i, ctl, retired, C_HALT);
            end
            step();
        end
        start = 1'b0;
    endtask

    task automatic test_illegal();
        apply_reset();
        launch();
        do_fetch(16'h8000, 0, "ill_jmp");
        step();
        exp_ret++;
        do_fetch(16'hB000, 0, "ill");
        for (int i = 0; i < 50; i++) begin
            start     = (i % 5 == 0);
            mem_ready = i[0];
            #1;
            checks++;
            if (ctl !== C_HALT_ILL || retired !== exp_ret) begin
                failures++;
                $display("[TB] FAIL illegal cyc=%0d ctl=%b ret=%0d exp=%b ret=%0d",
                         i, ctl, retired, C_HALT_ILL, exp_ret);
            end
            step();
        end
        start     = 1'b0;
        mem_ready = 1'b0;
    endtask

    task automatic test_wrap();
        apply_reset();
        launch();
        for (int n = 0; n < (1 << TB_CNT_LEN); n++) begin
            do_fetch(16'h8000, 0, "wrap");
            if (n == (1 << TB_CNT_LEN) - 1) begin
                checks++;
                if (retired !== exp_ret) begin
                    failures++;
                    $display("[TB] FAIL wrap_max got=%0d exp=%0d", retired, exp_ret);
                end
            end
            step();
            exp_ret++;
        end
        #1;
        checks++;
        if (retired !== '0 || exp_ret !== '0) begin
            failures++;
            $display("[TB] FAIL wrap_zero got=%0d exp=0", retired);
        end
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_alu_ops();
        test_store();
        test_branch();
        test_jump();
        test_reset_mem_wr();
        test_load();
        test_halt();
        test_illegal();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multi-cycle FSM controller for the 16-bit processor.
- Sequences the program counter (drives its pc_wr_en/pc_src), the instruction register, the memory port, the ALU and the register file through fetch/decode/execute/memory/writeback.
- Decodes the 4-bit opcode in instr[15:12] and counts retired instructions.

Parameters:
- DATA_LEN, 16, instruction/data word width.
- OPCODE_LEN, 4, opcode field width, located at instr[DATA_LEN-1 -: OPCODE_LEN].
- CNT_LEN, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; leaves IDLE.
- instr  in  DATA_LEN  IR contents; valid from DECODE onward.
- alu_zero  in  1  ALU result == 0, combinational from the datapath.
- mem_ready  in  1  memory completes the current request.
- mem_req  out  1  memory request.
- mem_we  out  1  write strobe; valid with mem_req.
- mem_addr_sel  out  1  0 = PC address, 1 = ALU result address.
- ir_wr_en  out  1  load IR from memory data.
- pc_wr_en  out  1  PC write enable.
- pc_src  out  1  0 = PC+1, 1 = load ALU/target data.
- alu_op  out  2  00 ADD, 01 SUB, 10 AND, 11 OR.
- alu_src_b  out  1  0 = register B, 1 = sign-extended imm8 (instr[7:0]).
- rf_wr_en  out  1  register file write.
- rf_wr_sel  out  1  0 = ALU result, 1 = memory data.
- halted  out  1  FSM is in HALT.
- illegal  out  1  sticky; set on an undefined opcode.
- retired  out  CNT_LEN  retired-instruction count.

Behaviour:
- Reset (async): state=IDLE, all outputs 0, retired=0, illegal=0. Reset mid-transaction drops mem_req immediately; no completion is owed to memory.
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 ADDI, 5 LD, 6 ST, 7 BEQ, 8 JMP, E HALT. All others are illegal.
- IDLE: outputs 0. start=1 -> FETCH.
- FETCH:
  - mem_req=1, mem_addr_sel=0, mem_we=0.
  - mem_ready=1 in the same cycle (Mealy): ir_wr_en=1, pc_wr_en=1, pc_src=0, then -> DECODE.
  - Otherwise hold FETCH with request outputs held stable.
- DECODE: 1 cycle, no strobes. Next state:
  - 0-3 -> EXEC_R
  - 4 -> EXEC_I
  - 5/6 -> ADDR
  - 7 -> BRANCH
  - 8 -> JUMP
  - E -> HALT
  - other -> HALT with illegal set on that edge.
- EXEC_R: alu_op=opcode[1:0], alu_src_b=0 -> WB_ALU.
- EXEC_I: alu_op=ADD, alu_src_b=1 -> WB_ALU.
- WB_ALU: rf_wr_en=1, rf_wr_sel=0, alu_op/alu_src_b held from the previous state -> FETCH.
- ADDR: alu_op=ADD, alu_src_b=1 -> MEM_RD (LD) or MEM_WR (ST).
- MEM_RD: mem_req=1, mem_addr_sel=1, ALU controls held. Wait for mem_ready -> WB_MEM.
- WB_MEM: rf_wr_en=1, rf_wr_sel=1 -> FETCH.
- MEM_WR: mem_req=1, mem_we=1, mem_addr_sel=1. Wait for mem_ready -> FETCH.
- BRANCH: alu_op=SUB, alu_src_b=0. If alu_zero=1 (Mealy): pc_wr_en=1, pc_src=1. -> FETCH in both cases.
- JUMP: pc_wr_en=1, pc_src=1 -> FETCH.
- HALT: halted=1, all strobes 0. Stays in HALT until rst; start is ignored.
- Memory handshake:
  - mem_ready is only sampled while mem_req=1; it is ignored otherwise.
  - Wait is unbounded.
  - mem_req deasserts in the cycle after the accepting edge.
- Retire counter:
  - +1 on the edge leaving WB_ALU, WB_MEM, MEM_WR, BRANCH or JUMP.
  - HALT and illegal opcodes do not retire.
  - Wraps 0xFFFF -> 0x0000.
- Latencies with zero-wait memory: ALU/ADDI 4 cycles; LD 5; ST 4; BEQ/JMP 3.
- pc_wr_en never asserts outside FETCH/BRANCH/JUMP.
- At most one of ir_wr_en, rf_wr_en, mem_we is asserted per cycle.

Decomposition:
- Package mc_cpu_pkg holds:
  - state_e enum (IDLE, FETCH, DECODE, EXEC_R, EXEC_I, WB_ALU, ADDR, MEM_RD, WB_MEM, MEM_WR, BRANCH, JUMP, HALT)
  - opcode_e
  - alu_op_e
  - PC_SRC_INC/PC_SRC_LOAD, ADDR_PC/ADDR_ALU, WB_ALU_SEL/WB_MEM_SEL constants
- One sub-module, mc_instr_decoder: combinational, maps instr[15:12] to an instruction-class enum plus an illegal flag.
- FSM, output logic and retire counter stay in mc_control_unit.

Test Plan:
- Reset, start, memory returns instr 0x0123 (ADD) with mem_ready=1 immediately -> states FETCH, DECODE, EXEC_R, WB_ALU; pc_wr_en=1 & pc_src=0 only in the FETCH cycle; rf_wr_en=1 for exactly 1 cycle; retired=1.
- LD 0x5104 with mem_ready delayed 3 cycles in both FETCH and MEM_RD -> mem_req stays high through each wait; mem_addr_sel=1 in MEM_RD; rf_wr_sel=1 in WB_MEM; 11 cycles start-to-FETCH.
- BEQ 0x7xxx, run once with alu_zero=1 and once with alu_zero=0 -> pc_wr_en=1 & pc_src=1 in BRANCH only in the taken case; retired increments by 1 in both.
- Opcode 0xB -> HALT after DECODE; illegal=1 and halted=1 held for 50 cycles despite start pulses; retired unchanged.
- Assert rst during MEM_WR with mem_req=1 -> all outputs 0 before the next clock edge; state IDLE; retired=0.
- Force retired to 0xFFFF via 65535 JMP instructions (or a preload hook) then one more JMP -> retired=0x0000.
